// File: rtl/clock_frequency_divider.sv
// ---------------------------------------------------------------------------
// clock_frequency_divider
//
// Purpose:
//   Derives a slow clock with a 50% duty cycle (OutClock) from a fast source
//   clock (InClock). It counts InClock cycles and toggles OutClock once every
//   half output period. It also produces a strobe (TickOut) that is high for
//   one InClock cycle, aligned with each rising edge of OutClock.
//
// Parameters:
//   INPUT_FREQUENCY   InClock frequency in Hz.
//   OUTPUT_FREQUENCY  Target OutClock frequency in Hz.
//
// Ports:
//   InClock   in   1  Source clock; all state advances on its rising edge.
//   resetApp  in   1  Asynchronous, active-high reset.
//   OutClock  out  1  Divided clock, registered, 50% duty cycle.
//   TickOut   out  1  High for the single InClock cycle in which OutClock
//                     has just risen.
// ---------------------------------------------------------------------------
module clock_frequency_divider #(
  parameter int INPUT_FREQUENCY  = 50_000_000,
  parameter int OUTPUT_FREQUENCY = 1
) (
  input  logic InClock,
  input  logic resetApp,
  output logic OutClock,
  output logic TickOut
);

  // A zero output frequency would divide by zero at elaboration, so it is
  // treated as 1 Hz. A half period below one cycle is clamped to one cycle,
  // which gives InClock/2.
  localparam int OUT_FREQ_SAFE = (OUTPUT_FREQUENCY < 1) ? 1 : OUTPUT_FREQUENCY;
  localparam int HALF_RAW      = INPUT_FREQUENCY / (2 * OUT_FREQ_SAFE);
  localparam int HALF_PERIOD   = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int CNT_RAW       = $clog2(HALF_PERIOD + 1);
  localparam int CNT_WIDTH     = (CNT_RAW < 1) ? 1 : CNT_RAW;

  localparam logic [CNT_WIDTH-1:0] LAST_COUNT = CNT_WIDTH'(HALF_PERIOD - 1);

  logic [CNT_WIDTH-1:0] halfCount;

  // The comparison uses >= rather than ==. This keeps any unexpected counter
  // value from running past the wrap point.
  // TickOut takes the inverted old OutClock value. It is therefore set only
  // on the toggle that drives OutClock from 0 to 1.
  always_ff @(posedge InClock or posedge resetApp) begin
    if (resetApp) begin
      halfCount <= '0;
      OutClock  <= 1'b0;
      TickOut   <= 1'b0;
    end else if (halfCount >= LAST_COUNT) begin
      halfCount <= '0;
      OutClock  <= ~OutClock;
      TickOut   <= ~OutClock;
    end else begin
      halfCount <= halfCount + 1'b1;
      TickOut   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_frequency_divider.sv
// ---------------------------------------------------------------------------
// tb_clock_frequency_divider
//
// Purpose:
//   Self-checking bench for clock_frequency_divider. Five instances run from
//   one clock:
//     A  100/10  half period 5, reset again partway through operation
//     B  100/100 half period clamps to 1
//     C  100/15  half period 3 (the ratio is truncated)
//     D  410/10  half period 20 (truncated), run for 1000 output periods
//     E  100/10  half period 5, never disturbed after the first release
//   Expected outputs come from the number of edges since reset release:
//     OutClock = floor(k / HP) is odd
//     TickOut  = (k mod 2*HP) == HP
// ---------------------------------------------------------------------------
module tb_clock_frequency_divider;

  function automatic int halfOf(input int fin, input int fout);
    int h;
    h = fin / (2 * fout);
    return (h < 1) ? 1 : h;
  endfunction

  localparam int HP_A = halfOf(100, 10);
  localparam int HP_B = halfOf(100, 100);
  localparam int HP_C = halfOf(100, 15);
  localparam int HP_D = halfOf(410, 10);
  localparam int HP_E = halfOf(100, 10);

  logic clk = 1'b0;
  logic rstA = 1'b1;
  logic rstMain = 1'b1;
  logic outA, tickA, outB, tickB, outC, tickC, outD, tickD, outE, tickE;

  int checks = 0;
  int errors = 0;
  int kA = 0, kB = 0, kC = 0, kD = 0, kE = 0;
  int runD = 0;
  logic prevD = 1'b0;

  always #5 clk = ~clk;

  clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dutA (
    .InClock(clk), .resetApp(rstA), .OutClock(outA), .TickOut(tickA));
  clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(100)) dutB (
    .InClock(clk), .resetApp(rstMain), .OutClock(outB), .TickOut(tickB));
  clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(15)) dutC (
    .InClock(clk), .resetApp(rstMain), .OutClock(outC), .TickOut(tickC));
  clock_frequency_divider #(.INPUT_FREQUENCY(410), .OUTPUT_FREQUENCY(10)) dutD (
    .InClock(clk), .resetApp(rstMain), .OutClock(outD), .TickOut(tickD));
  clock_frequency_divider #(.INPUT_FREQUENCY(100), .OUTPUT_FREQUENCY(10)) dutE (
    .InClock(clk), .resetApp(rstMain), .OutClock(outE), .TickOut(tickE));

  function automatic logic expOut(input int k, input int hp);
    return ((k / hp) % 2) == 1;
  endfunction

  function automatic logic expTick(input int k, input int hp);
    return (k > 0) && ((k % (2 * hp)) == hp);
  endfunction

  task automatic chk(input string tag, input int edgeNo, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed %0b expected %0b", tag, edgeNo, obs, exp);
    end
  endtask

  task automatic chkAll(input int edgeNo);
    chk("outA", edgeNo, outA, expOut(kA, HP_A));
    chk("tickA", edgeNo, tickA, expTick(kA, HP_A));
    chk("outB", edgeNo, outB, expOut(kB, HP_B));
    chk("tickB", edgeNo, tickB, expTick(kB, HP_B));
    chk("outC", edgeNo, outC, expOut(kC, HP_C));
    chk("tickC", edgeNo, tickC, expTick(kC, HP_C));
    chk("outD", edgeNo, outD, expOut(kD, HP_D));
    chk("tickD", edgeNo, tickD, expTick(kD, HP_D));
    chk("outE", edgeNo, outE, expOut(kE, HP_E));
    chk("tickE", edgeNo, tickE, expTick(kE, HP_E));
  endtask

  // Advance one InClock edge, update the model, and check every instance.
  // The phase length of D is also checked directly whenever OutClock changes.
  task automatic step(input int edgeNo);
    @(posedge clk);
    #1;
    if (!rstA) kA++;
    if (!rstMain) begin
      kB++; kC++; kD++; kE++;
      runD++;
    end
    chkAll(edgeNo);
    if (outD !== prevD) begin
      chk("phaseLenD", edgeNo, logic'(runD == HP_D), 1'b1);
      runD = 0;
      prevD = outD;
    end
  endtask

  initial begin
    // Hold reset across a few edges; every output must stay low.
    repeat (3) begin
      @(posedge clk);
      #1;
      chkAll(-1);
    end
    // Release all resets just after edge 0.
    rstA = 1'b0;
    rstMain = 1'b0;

    for (int e = 1; e <= 7; e++) step(e);

    // Assert reset on A while its OutClock is high. The output must drop
    // before the next clock edge.
    rstA = 1'b1;
    #1;
    kA = 0;
    chk("asyncRstOutA", 7, outA, 1'b0);
    chk("asyncRstTickA", 7, tickA, 1'b0);

    step(8);
    step(9);
    rstA = 1'b0;  // released after edge 9, so the next rise is expected at edge 14

    // Run D through 1000 full output periods from the first release.
    for (int e = 10; e <= 2 * HP_D * 1000; e++) step(e);

    chk("periodsDone", 0, logic'(kD == 2 * HP_D * 1000), 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
